// File: rtl/core_pkg.sv
// Shared core constants: default register-file geometry and the hardwired-zero index.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);
    localparam int X0_IDX = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback or flush.
module regfile_scoreboard #(
    parameter int NREG = core_pkg::NREG,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] ra,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_rd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              flush,
    output logic [NRD-1:0]    busy_raw,
    output logic [AW:0]       npend
);
    import core_pkg::*;

    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [AW:0]     npend_reg;
    logic [AW:0]     npend_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == X0_IDX) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                // A new producer supersedes a same-cycle retirement; flush overrides both.
                assign pending_next[gi] = flush                          ? 1'b0 :
                                          (iss_v && iss_rd == AW'(gi))   ? 1'b1 :
                                          (we && wa == AW'(gi))          ? 1'b0 :
                                          pending_reg[gi];
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            assign busy_raw[gi] = pending_reg[ra[gi*AW +: AW]];
        end
    endgenerate

    always_comb begin
        npend_next = '0;
        for (int i = 0; i < NREG; i++) begin
            npend_next = npend_next + (AW+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            npend_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            npend_reg   <= npend_next;
        end
    end

    assign npend = npend_reg;
endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: NRD combinational read ports, one write port,
// optional WB-to-read bypass, and a pending-write scoreboard.
module regfile_sb #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREG   = core_pkg::NREG,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         npend
);
    import core_pkg::*;

    logic [XLEN-1:0] mem_reg [NREG];
    logic [NRD-1:0]  busy_raw;
    logic            wr_live;

    // x0 is never written, so it stays at its reset value of zero.
    assign wr_live = we && (wa != AW'(X0_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_live) begin
            mem_reg[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .we       (we),
        .wa       (wa),
        .flush    (flush),
        .busy_raw (busy_raw),
        .npend    (npend)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0] ra_k;
            logic          hit;
            assign ra_k = ra[gi*AW +: AW];
            assign hit  = (BYPASS != 0) && wr_live && (wa == ra_k);
            assign rd[gi*XLEN +: XLEN] = hit ? wd : mem_reg[ra_k];
            assign busy[gi]            = hit ? 1'b0 : busy_raw[gi];
        end
    endgenerate
endmodule
